bitlet_act_streamer: RTL and testbench

Transmit-side feeder for the Bitlet preprocessor's activation input. It accepts one full activation vector per job, then streams it as `N_input`-wide beats on `Abin_vld`/`Abin_vec`, exactly `N_total/N_input` beats per job. It then waits for the preprocessor's `finish` pulse, or a timeout, and closes the job with a one-cycle `flush`. It sits between the activation fetch logic and the preprocessor inside the Bitlet PE.

---
 rtl/bitlet_act_streamer.sv | 115 +++++++++++
 tb/tb_bitlet_act_streamer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bitlet_act_streamer.sv
// Bitlet activation streamer: latches one activation vector per job,
// issues it as fixed-width beats, then waits for finish/timeout and flushes.
module bitlet_act_streamer #(
  parameter int N_total  = 64,
  parameter int N_input  = 16,
  parameter int WAIT_MAX = 255,
  parameter int Wid_bin  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         job_vld,
  output logic                         job_rdy,
  input  logic [N_total*Wid_bin-1:0]   job_Abin,
  input  logic                         pause,
  output logic                         Abin_vld,
  output logic [N_input*Wid_bin-1:0]   Abin_vec,
  input  logic                         finish,
  output logic                         flush,
  output logic                         done,
  output logic                         timeout,
  output logic                         busy
);

  localparam int P_INPUT = N_total / N_input;
  localparam int BW      = $clog2(P_INPUT);
  localparam int BEAT_W  = N_input * Wid_bin;

  localparam logic [BW-1:0] LAST_BEAT = BW'(P_INPUT - 1);
  localparam logic [15:0]   WAIT_LAST = 16'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [N_total*Wid_bin-1:0] buf_q;
  logic [BW-1:0]              beat_cnt;
  logic [15:0]                wait_cnt;
  logic                       ok_q;

  logic [BEAT_W-1:0] slices [P_INPUT];

  for (genvar k = 0; k < P_INPUT; k++) begin : g_slice
    assign slices[k] = buf_q[k*BEAT_W +: BEAT_W];
  end

  // Beat data is a pure mux of registered state, never X after reset.
  assign Abin_vec = slices[beat_cnt];

  always_comb begin
    state_d  = state_q;
    job_rdy  = 1'b0;
    busy     = 1'b1;
    Abin_vld = 1'b0;
    flush    = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        job_rdy = 1'b1;
        busy    = 1'b0;
        if (job_vld) state_d = STREAM;
      end
      STREAM: begin
        Abin_vld = !pause;
        if (!pause && beat_cnt == LAST_BEAT)
          state_d = WAIT;
      end
      WAIT: begin
        if (finish || wait_cnt == WAIT_LAST)
          state_d = FLUSH;
      end
      FLUSH: begin
        flush   = 1'b1;
        done    = ok_q;
        timeout = !ok_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      ok_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && job_vld) begin
        buf_q    <= job_Abin;
        beat_cnt <= '0;
      end

      if (state_q == STREAM && !pause) begin
        if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
        else                       beat_cnt <= beat_cnt + 1'b1;
      end

      if (state_q == WAIT) wait_cnt <= wait_cnt + 16'd1;
      else                 wait_cnt <= '0;

      // finish wins a tie with the timeout, so it alone decides the flag
      if (state_q == WAIT) ok_q <= finish;
    end
  end

endmodule

// File: tb/tb_bitlet_act_streamer.sv
// Directed bench for bitlet_act_streamer: basic, pause, timeout, tie,
// back-to-back and mid-job reset scenarios.
module tb_bitlet_act_streamer;

  localparam int NT = 64;
  localparam int NI = 16;
  localparam int W  = 8;
  localparam int WM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic job_vld = 1'b0;
  logic pause = 1'b0;
  logic finish = 1'b0;
  logic [NT*W-1:0] job_Abin = '0;
  logic job_rdy, Abin_vld, flush, done, timeout, busy;
  logic [NI*W-1:0] Abin_vec;

  int errs = 0;
  int checks = 0;

  bitlet_act_streamer #(
    .N_total(NT), .N_input(NI), .WAIT_MAX(WM), .Wid_bin(W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_vld(job_vld), .job_rdy(job_rdy), .job_Abin(job_Abin),
    .pause(pause), .Abin_vld(Abin_vld), .Abin_vec(Abin_vec),
    .finish(finish), .flush(flush), .done(done),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NT*W-1:0] pat(bit inv);
    logic [NT*W-1:0] v;
    for (int i = 0; i < NT; i++)
      v[i*W +: W] = inv ? 8'(255 - i) : 8'(i);
    return v;
  endfunction

  function automatic logic [NI*W-1:0] beat(int k, bit inv);
    logic [NI*W-1:0] v;
    for (int j = 0; j < NI; j++)
      v[j*W +: W] = inv ? 8'(255 - (k*NI + j)) : 8'(k*NI + j);
    return v;
  endfunction

  task automatic chk(string tag, logic [NI*W-1:0] obs,
                     logic [NI*W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // order: job_rdy busy Abin_vld flush done timeout
  task automatic ctl(string tag, logic [5:0] expv);
    chk(tag, {122'd0, job_rdy, busy, Abin_vld, flush, done, timeout},
        {122'd0, expv});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3;
    ctl("rst_ctl", 6'b100000);
    chk("rst_vec", Abin_vec, '0);
    tick(); tick();
    rst_n = 1'b1;

    // basic job
    tick(); job_Abin = pat(0); job_vld = 1'b1; #1;
    ctl("b_hs", 6'b100000);
    for (int k = 0; k < 4; k++) begin
      tick(); job_vld = 1'b0; #1;
      ctl("b_beat_ctl", 6'b011000);
      chk("b_beat_vec", Abin_vec, beat(k, 0));
    end
    for (int w = 0; w < 3; w++) begin
      tick(); #1; ctl("b_wait", 6'b010000);
    end
    tick(); finish = 1'b1; #1; ctl("b_fin", 6'b010000);
    tick(); finish = 1'b0; #1; ctl("b_flush", 6'b010110);
    tick(); #1; ctl("b_idle", 6'b100000);

    // pause in cycles 2-3 of the stream
    tick(); job_vld = 1'b1; #1; ctl("p_hs", 6'b100000);
    tick(); job_vld = 1'b0; #1;
    ctl("p_b0_ctl", 6'b011000);
    chk("p_b0_vec", Abin_vec, beat(0, 0));
    tick(); pause = 1'b1; #1; ctl("p_stall0", 6'b010000);
    tick(); #1; ctl("p_stall1", 6'b010000);
    for (int k = 1; k < 4; k++) begin
      tick(); pause = 1'b0; #1;
      ctl("p_beat_ctl", 6'b011000);
      chk("p_beat_vec", Abin_vec, beat(k, 0));
    end
    tick(); finish = 1'b1; #1; ctl("p_wait", 6'b010000);
    tick(); finish = 1'b0; #1; ctl("p_flush", 6'b010110);
    tick(); #1; ctl("p_idle", 6'b100000);

    // timeout
    tick(); job_vld = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      tick(); job_vld = 1'b0; #1; ctl("t_beat", 6'b011000);
    end
    for (int w = 0; w < WM; w++) begin
      tick(); #1; ctl("t_wait", 6'b010000);
    end
    tick(); #1; ctl("t_flush", 6'b010101);
    tick(); #1; ctl("t_idle", 6'b100000);

    // finish on the last WAIT cycle
    tick(); job_vld = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      tick(); job_vld = 1'b0; #1;
    end
    for (int w = 0; w < WM; w++) begin
      tick(); finish = (w == WM - 1); #1; ctl("tie_wait", 6'b010000);
    end
    tick(); finish = 1'b0; #1; ctl("tie_flush", 6'b010110);
    tick(); #1; ctl("tie_idle", 6'b100000);

    // back-to-back, job_vld held, stray finish, bus changes mid-job
    tick(); job_Abin = pat(0); job_vld = 1'b1; #1;
    ctl("bb_hs1", 6'b100000);
    tick(); job_Abin = pat(1); #1;
    chk("bb_j1b0", Abin_vec, beat(0, 0));
    tick(); finish = 1'b1; #1;
    ctl("bb_stray", 6'b011000);
    chk("bb_j1b1", Abin_vec, beat(1, 0));
    tick(); finish = 1'b0; #1; chk("bb_j1b2", Abin_vec, beat(2, 0));
    tick(); #1; chk("bb_j1b3", Abin_vec, beat(3, 0));
    tick(); finish = 1'b1; #1; ctl("bb_wait", 6'b010000);
    tick(); finish = 1'b0; #1; ctl("bb_flush", 6'b010110);
    tick(); #1; ctl("bb_hs2", 6'b100000);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      ctl("bb_j2_ctl", 6'b011000);
      chk("bb_j2_vec", Abin_vec, beat(k, 1));
    end
    tick(); job_vld = 1'b0; #1; ctl("bb_no5th", 6'b010000);
    tick(); finish = 1'b1; #1;
    tick(); finish = 1'b0; #1; ctl("bb_flush2", 6'b010110);
    tick(); #1; ctl("bb_idle", 6'b100000);

    // reset during the second beat
    tick(); job_Abin = pat(0); job_vld = 1'b1; #1;
    tick(); job_vld = 1'b0; #1;
    tick(); #1;
    chk("r_b1", Abin_vec, beat(1, 0));
    rst_n = 1'b0; #1;
    ctl("r_async", 6'b100000);
    chk("r_vec", Abin_vec, '0);
    tick(); #1; ctl("r_hold", 6'b100000);
    rst_n = 1'b1;
    tick(); job_vld = 1'b1; #1; ctl("r_hs", 6'b100000);
    tick(); job_vld = 1'b0; #1;
    ctl("r_b0_ctl", 6'b011000);
    chk("r_b0_vec", Abin_vec, beat(0, 0));
    tick(); #1; chk("r_b1_vec", Abin_vec, beat(1, 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
